// File: rtl/spi_word_sequencer_if.sv
// Handshake bundle between a word producer, the word sequencer and a single-CS SPI master.
// The slave modport is the sequencer's view; the master modport is the view of whoever drives it.
interface spi_word_sequencer_if #(
  parameter int BYTES_PER_WORD = 3,
  parameter int COUNT_W        = $clog2(BYTES_PER_WORD + 1)
);
  logic [8*BYTES_PER_WORD-1:0] i_Word;
  logic                        i_Word_DV;
  logic                        o_Word_Ready;
  logic                        o_Busy;
  logic                        o_Done;
  logic [8*BYTES_PER_WORD-1:0] o_RX_Word;
  logic [COUNT_W-1:0]          o_TX_Count;
  logic [7:0]                  o_TX_Byte;
  logic                        o_TX_DV;
  logic                        i_TX_Ready;
  logic                        i_RX_DV;
  logic [7:0]                  i_RX_Byte;
  logic                        i_SPI_CS_n;

  modport slave (
    input  i_Word, i_Word_DV, i_TX_Ready, i_RX_DV, i_RX_Byte, i_SPI_CS_n,
    output o_Word_Ready, o_Busy, o_Done, o_RX_Word, o_TX_Count, o_TX_Byte, o_TX_DV
  );

  modport master (
    output i_Word, i_Word_DV, i_TX_Ready, i_RX_DV, i_RX_Byte, i_SPI_CS_n,
    input  o_Word_Ready, o_Busy, o_Done, o_RX_Word, o_TX_Count, o_TX_Byte, o_TX_DV
  );
endinterface

// File: rtl/spi_word_sequencer.sv
// Feeds one N-byte word MSB-first into the SPI master under a single CS-low pulse and reassembles MISO.
// First TX_DV one cycle after accept (if master ready); one word at a time, new words held off until CS is high.
module spi_word_sequencer #(
  parameter int BYTES_PER_WORD = 3,
  parameter int COUNT_W        = $clog2(BYTES_PER_WORD + 1)
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  spi_word_sequencer_if.slave  bus
);
  localparam int                 W   = 8 * BYTES_PER_WORD;
  localparam logic [COUNT_W-1:0] N_C = COUNT_W'(BYTES_PER_WORD);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, FINISH} state_t;

  state_t             state;
  logic [W-1:0]       tx_shift;
  logic [W-1:0]       rx_shift;
  logic [W-1:0]       rx_shift_nxt;
  logic [W-1:0]       rx_word;
  logic [COUNT_W-1:0] byte_idx;
  logic [COUNT_W-1:0] rx_count;
  logic [COUNT_W-1:0] rx_count_nxt;
  logic [7:0]         tx_byte;
  logic               tx_dv;
  logic               done;

  // RX capture runs in every non-idle state so a byte landing on the DRAIN->FINISH edge is kept.
  always_comb begin
    rx_shift_nxt = rx_shift;
    rx_count_nxt = rx_count;
    if (state != IDLE && bus.i_RX_DV) begin
      rx_shift_nxt = W'({rx_shift, bus.i_RX_Byte});
      if (rx_count != N_C) rx_count_nxt = rx_count + COUNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_word  <= '0;
      byte_idx <= '0;
      rx_count <= '0;
      tx_byte  <= '0;
      tx_dv    <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_dv    <= 1'b0;
      done     <= 1'b0;
      rx_shift <= rx_shift_nxt;
      rx_count <= rx_count_nxt;
      case (state)
        IDLE: begin
          if (bus.i_Word_DV && bus.i_SPI_CS_n) begin
            tx_shift <= bus.i_Word;
            byte_idx <= '0;
            rx_count <= '0;
            rx_shift <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_TX_Ready) begin
            tx_dv    <= 1'b1;
            tx_byte  <= tx_shift[W-1 -: 8];
            tx_shift <= tx_shift << 8;
            byte_idx <= byte_idx + COUNT_W'(1);
            state    <= GAP;
          end
        end
        // Master's ready only drops the cycle after our DV, so skip one cycle before looking again.
        GAP: state <= (byte_idx < N_C) ? ISSUE : DRAIN;
        DRAIN: begin
          if (rx_count == N_C && bus.i_SPI_CS_n) begin
            done    <= 1'b1;
            rx_word <= rx_shift_nxt;
            state   <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Word_Ready = (state == IDLE) && bus.i_SPI_CS_n;
  assign bus.o_Busy       = (state != IDLE);
  assign bus.o_Done       = done;
  assign bus.o_RX_Word    = rx_word;
  assign bus.o_TX_Count   = N_C;
  assign bus.o_TX_Byte    = tx_byte;
  assign bus.o_TX_DV      = tx_dv;
endmodule

// File: tb/tb_spi_word_sequencer.sv
// Directed bench: a small SPI-master model answers the 3-byte sequencer; a 1-byte instance is driven by hand.
module tb_spi_word_sequencer;
  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  spi_word_sequencer_if #(.BYTES_PER_WORD(3)) sif  ();
  spi_word_sequencer_if #(.BYTES_PER_WORD(1)) sif1 ();

  spi_word_sequencer #(.BYTES_PER_WORD(3)) dut  (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(sif.slave));
  spi_word_sequencer #(.BYTES_PER_WORD(1)) dut1 (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(sif1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model state and scoreboard
  int         stall = 0;
  logic [7:0] miso[$];
  logic [7:0] tx_log[$];
  int dv_cnt, done_cnt, ready_viol, adj_viol, done_cs_low, min_gap, last_dv_cyc, cyc;
  int bit_tmr, post_tmr, cs_tmr, bytes_in_word;
  logic prev_dv;
  int dv1_cnt, done1_cnt;
  logic [7:0] byte1;

  initial begin
    sif.i_TX_Ready = 1'b1; sif.i_SPI_CS_n = 1'b1; sif.i_RX_DV = 1'b0; sif.i_RX_Byte = 8'h00;
    cyc = 0; bit_tmr = 0; post_tmr = 0; cs_tmr = 0; bytes_in_word = 0; prev_dv = 1'b0;
    dv1_cnt = 0; done1_cnt = 0; byte1 = 8'h00;
    forever begin
      @(posedge i_Clk); #2;
      cyc++;
      sif.i_RX_DV = 1'b0;
      if (sif.o_TX_DV) begin
        if (!sif.i_TX_Ready) ready_viol++;
        if (prev_dv) adj_viol++;
        if (dv_cnt > 0 && cyc - last_dv_cyc < min_gap) min_gap = cyc - last_dv_cyc;
        last_dv_cyc = cyc;
        dv_cnt++;
        tx_log.push_back(sif.o_TX_Byte);
        sif.i_TX_Ready = 1'b0; sif.i_SPI_CS_n = 1'b0;
        bit_tmr = 4; bytes_in_word++;
      end else if (bit_tmr > 0) begin
        bit_tmr--;
        if (bit_tmr == 0) begin
          sif.i_RX_DV   = 1'b1;
          sif.i_RX_Byte = (miso.size() > 0) ? miso.pop_front() : 8'h00;
          if (bytes_in_word >= 3) begin cs_tmr = 2; bytes_in_word = 0; end
          else if (stall == 0) sif.i_TX_Ready = 1'b1;
          else post_tmr = stall;
        end
      end else if (post_tmr > 0) begin
        post_tmr--;
        if (post_tmr == 0) sif.i_TX_Ready = 1'b1;
      end else if (cs_tmr > 0) begin
        cs_tmr--;
        if (cs_tmr == 0) begin sif.i_SPI_CS_n = 1'b1; sif.i_TX_Ready = 1'b1; end
      end
      if (sif.o_Done) begin
        done_cnt++;
        if (!sif.i_SPI_CS_n) done_cs_low++;
      end
      prev_dv = sif.o_TX_DV;
      if (sif1.o_TX_DV) begin dv1_cnt++; byte1 = sif1.o_TX_Byte; end
      if (sif1.o_Done) done1_cnt++;
      if (i_Rst) begin
        sif.i_TX_Ready = 1'b1; sif.i_SPI_CS_n = 1'b1; sif.i_RX_DV = 1'b0;
        bit_tmr = 0; post_tmr = 0; cs_tmr = 0; bytes_in_word = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_Clk); #1; end
  endtask

  task automatic clear_logs();
    tx_log.delete(); miso.delete();
    dv_cnt = 0; done_cnt = 0; ready_viol = 0; adj_viol = 0; done_cs_low = 0; min_gap = 1000;
  endtask

  function automatic logic [63:0] log_val();
    logic [63:0] v = '0;
    for (int i = 0; i < tx_log.size(); i++) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  task automatic send_word(input logic [23:0] w);
    int k = 0;
    while (!sif.o_Word_Ready && k < 200) begin tick(1); k++; end
    check_eq("accept_wait", k < 200, 1);
    sif.i_Word = w; sif.i_Word_DV = 1'b1;
    tick(1);
    sif.i_Word_DV = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 2000) begin tick(1); k++; end
    check_eq(tag, done_cnt >= target, 1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int k = 0;
    while (sif.o_Busy !== lvl && k < 500) begin tick(1); k++; end
    check_eq(tag, sif.o_Busy, lvl);
  endtask

  task automatic wait_dv(input int target, input string tag);
    int k = 0;
    while (dv_cnt < target && k < 500) begin tick(1); k++; end
    check_eq(tag, dv_cnt >= target, 1);
  endtask

  initial begin
    int k;
    sif.i_Word = '0; sif.i_Word_DV = 1'b0;
    sif1.i_Word = '0; sif1.i_Word_DV = 1'b0; sif1.i_TX_Ready = 1'b1; sif1.i_SPI_CS_n = 1'b1;
    sif1.i_RX_DV = 1'b0; sif1.i_RX_Byte = 8'h00;
    clear_logs();

    // Reset state
    repeat (4) @(posedge i_Clk);
    #1;
    check_eq("rst_busy", sif.o_Busy, 0);
    check_eq("rst_tx_dv", sif.o_TX_DV, 0);
    check_eq("rst_done", sif.o_Done, 0);
    check_eq("rst_rx_word", sif.o_RX_Word, 0);
    check_eq("rst_tx_byte", sif.o_TX_Byte, 0);
    check_eq("rst_word_ready", sif.o_Word_Ready, 1);
    check_eq("rst_tx_count", sif.o_TX_Count, 3);
    i_Rst = 1'b0;
    tick(2);

    // 1: basic send and readback
    clear_logs();
    miso.push_back(8'hA1); miso.push_back(8'hB2); miso.push_back(8'hC3);
    send_word(24'h123456);
    wait_done(1, "t1_done_wait");
    tick(5);
    check_eq("t1_dv_cnt", dv_cnt, 3);
    check_eq("t1_bytes", log_val(), 64'h123456);
    check_eq("t1_ready_viol", ready_viol, 0);
    check_eq("t1_tx_count", sif.o_TX_Count, 3);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_done_cs_low", done_cs_low, 0);
    check_eq("t1_rx_word", sif.o_RX_Word, 64'hA1B2C3);
    check_eq("t1_busy_after", sif.o_Busy, 0);

    // 2: back-to-back words with Word_DV held high
    clear_logs();
    for (int i = 1; i <= 6; i++) miso.push_back(8'(8'h11 * i));
    sif.i_Word = 24'h0000FF; sif.i_Word_DV = 1'b1;
    wait_busy(1'b1, "t2_first_accept");
    sif.i_Word = 24'h800001;
    wait_done(1, "t2_done1_wait");
    check_eq("t2_dv_before_2nd", dv_cnt, 3);
    wait_busy(1'b0, "t2_idle_between");
    wait_busy(1'b1, "t2_second_accept");
    sif.i_Word_DV = 1'b0;
    wait_done(2, "t2_done2_wait");
    tick(5);
    check_eq("t2_bytes", log_val(), 64'h0000FF800001);
    check_eq("t2_dv_cnt", dv_cnt, 6);
    check_eq("t2_done_cnt", done_cnt, 2);
    check_eq("t2_done_cs_low", done_cs_low, 0);
    check_eq("t2_rx_word", sif.o_RX_Word, 64'h445566);

    // 3: Word_DV while busy is ignored
    clear_logs();
    miso.push_back(8'h01); miso.push_back(8'h02); miso.push_back(8'h03);
    send_word(24'h111111);
    wait_dv(1, "t3_first_dv");
    sif.i_Word = 24'hDEADBE; sif.i_Word_DV = 1'b1;
    check_eq("t3_ready_busy", sif.o_Word_Ready, 0);
    tick(1);
    sif.i_Word_DV = 1'b0;
    wait_done(1, "t3_done_wait");
    tick(20);
    check_eq("t3_bytes", log_val(), 64'h111111);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_rx_word", sif.o_RX_Word, 64'h010203);

    // 4: master stalls ready for 20 cycles between bytes
    clear_logs();
    stall = 20;
    miso.push_back(8'h5E); miso.push_back(8'h6F); miso.push_back(8'h70);
    send_word(24'hA5C33C);
    wait_done(1, "t4_done_wait");
    tick(5);
    stall = 0;
    check_eq("t4_bytes", log_val(), 64'hA5C33C);
    check_eq("t4_ready_viol", ready_viol, 0);
    check_eq("t4_adjacent_dv", adj_viol, 0);
    check_eq("t4_stall_gap", min_gap >= 20, 1);
    check_eq("t4_rx_word", sif.o_RX_Word, 64'h5E6F70);

    // 5: reset mid-word, then a clean word
    clear_logs();
    miso.push_back(8'h21); miso.push_back(8'h22); miso.push_back(8'h23);
    send_word(24'hCAFE01);
    wait_dv(2, "t5_two_dv");
    i_Rst = 1'b1;
    tick(1);
    check_eq("t5_busy", sif.o_Busy, 0);
    check_eq("t5_tx_dv", sif.o_TX_DV, 0);
    check_eq("t5_rx_word", sif.o_RX_Word, 0);
    i_Rst = 1'b0;
    tick(10);
    check_eq("t5_no_done", done_cnt, 0);
    check_eq("t5_dv_cnt", dv_cnt, 2);
    clear_logs();
    miso.push_back(8'h31); miso.push_back(8'h32); miso.push_back(8'h33);
    send_word(24'h010203);
    wait_done(1, "t5_done_wait");
    tick(5);
    check_eq("t5_bytes", log_val(), 64'h010203);
    check_eq("t5_rx_word_after", sif.o_RX_Word, 64'h313233);
    check_eq("t5_done_cnt", done_cnt, 1);

    // 6: single-byte instance driven by hand
    check_eq("t6_tx_count", sif1.o_TX_Count, 1);
    k = 0;
    while (!sif1.o_Word_Ready && k < 50) begin tick(1); k++; end
    check_eq("t6_ready_wait", k < 50, 1);
    sif1.i_Word = 8'h5A; sif1.i_Word_DV = 1'b1;
    tick(1);
    sif1.i_Word_DV = 1'b0;
    k = 0;
    while (dv1_cnt < 1 && k < 50) begin tick(1); k++; end
    check_eq("t6_dv_wait", k < 50, 1);
    sif1.i_TX_Ready = 1'b0; sif1.i_SPI_CS_n = 1'b0;
    tick(3);
    sif1.i_RX_DV = 1'b1; sif1.i_RX_Byte = 8'h3C;
    tick(1);
    sif1.i_RX_DV = 1'b0;
    tick(2);
    check_eq("t6_no_early_done", done1_cnt, 0);
    sif1.i_SPI_CS_n = 1'b1; sif1.i_TX_Ready = 1'b1;
    k = 0;
    while (done1_cnt < 1 && k < 50) begin tick(1); k++; end
    check_eq("t6_done_wait", k < 50, 1);
    tick(5);
    check_eq("t6_dv_cnt", dv1_cnt, 1);
    check_eq("t6_tx_byte", byte1, 8'h5A);
    check_eq("t6_rx_word", sif1.o_RX_Word, 8'h3C);
    check_eq("t6_done_cnt", done1_cnt, 1);
    check_eq("t6_busy_after", sif1.o_Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end
endmodule
